run_sequencer: RTL and testbench

Host-side initiator for the processor's Start/Ack run protocol. It resets the processor, pulses Start, waits for Ack (the halt flag), measures the run length in cycles, and records a per-program cycle count and timeout flag. It then steps through NUM_PROGS programs in sequence. It sits beside the processor top level in the test/FPGA wrapper and drives that top level's Reset and Start inputs.

---
 rtl/run_seq_pkg.sv | 25 ++
 rtl/run_result_file.sv | 55 +++++
 rtl/run_sequencer.sv | 166 ++++++++++++++++
 tb/tb_run_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// Shared types and widths for the run sequencer.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package run_seq_pkg;

  localparam int CNT_W  = 16;
  localparam int PROG_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_START,
    S_BLANK,
    S_RUN,
    S_RECORD,
    S_FINISH
  } run_state_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/run_result_file.sv
// Per-program cycle-count store: one write port, combinational read, sync clear.
// Latency: a write is visible on the read port the cycle after we is high.
// Backpressure: none; writes always accepted.
module run_result_file
  import run_seq_pkg::*;
#(
  parameter int NUM_PROGS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [PROG_W-1:0] waddr,
  input  logic [CNT_W-1:0]  wdata,
  input  logic [PROG_W-1:0] raddr,
  output logic [CNT_W-1:0]  rdata
);

  logic [CNT_W-1:0] mem_q [NUM_PROGS];
  logic [CNT_W-1:0] mem_d [NUM_PROGS];

  // Next contents: clear wins over a write to the addressed entry.
  always_comb begin
    for (int i = 0; i < NUM_PROGS; i++) begin
      mem_d[i] = mem_q[i];
      if (clr) begin
        mem_d[i] = '0;
      end else if (we && (waddr == PROG_W'(i))) begin
        mem_d[i] = wdata;
      end
    end
  end

  // Storage; an async reset wipes every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read port; addresses beyond the last program read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (raddr == PROG_W'(i)) begin
        rdata = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// Host-side Start/Ack initiator: resets the processor, pulses Start, times each run, logs counts.
// Latency: Go sampled at edge N -> DutReset high N+1..N+RST_CYCLES, Start in cycle N+RST_CYCLES+1.
// Backpressure: none; Go is only sampled in IDLE and ignored while Busy.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int NUM_PROGS  = 3,
  parameter int RST_CYCLES = 2,
  parameter int ACK_BLANK  = 1,
  parameter int TIMEOUT    = 16'hFFFF
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Go,
  input  logic                 Ack,
  output logic                 DutReset,
  output logic                 Start,
  output logic [PROG_W-1:0]    ProgSel,
  output logic                 Busy,
  output logic                 Done,
  input  logic [PROG_W-1:0]    ResAddr,
  output logic [CNT_W-1:0]     ResCount,
  output logic [NUM_PROGS-1:0] TimeoutMask
);

  localparam logic [CNT_W-1:0]  RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(ACK_BLANK - 1);
  localparam logic [CNT_W-1:0]  TMO        = CNT_W'(TIMEOUT);
  localparam logic [PROG_W-1:0] LAST_PROG  = PROG_W'(NUM_PROGS - 1);

  run_state_t           state_q, state_d;
  logic [CNT_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PROG_W-1:0]    prog_q, prog_d;
  logic [NUM_PROGS-1:0] tmask_q, tmask_d;
  logic                 dut_reset_q, dut_reset_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rec_we;

  // Next state, counters and program bookkeeping.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    prog_d    = prog_q;
    tmask_d   = tmask_q;
    rec_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Go) begin
          prog_d    = '0;
          tmask_d   = '0;
          rst_cnt_d = '0;
          state_d   = S_RST;
        end
      end
      S_RST: begin
        if (rst_cnt_q >= RST_LAST) begin
          state_d = S_START;
        end else begin
          rst_cnt_d = rst_cnt_q + CNT_W'(1);
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_BLANK;
      end
      S_BLANK: begin
        // Blank cycles count toward the run; a stale Ack is not looked at here.
        cnt_d = sat_inc(cnt_q, TMO);
        if (cnt_q >= BLANK_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Ack is checked first, so Ack on the would-be timeout cycle wins.
        if (Ack) begin
          state_d = S_RECORD;
        end else begin
          cnt_d = sat_inc(cnt_q, TMO);
          if (cnt_d >= TMO) begin
            for (int i = 0; i < NUM_PROGS; i++) begin
              if (prog_q == PROG_W'(i)) begin
                tmask_d[i] = 1'b1;
              end
            end
            state_d = S_RECORD;
          end
        end
      end
      S_RECORD: begin
        rec_we = 1'b1;
        if (prog_q == LAST_PROG) begin
          state_d = S_FINISH;
        end else begin
          prog_d    = prog_q + PROG_W'(1);
          rst_cnt_d = '0;
          state_d   = S_RST;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    dut_reset_d = (state_d == S_RST);
    start_d     = (state_d == S_START);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH);
  end

  // State and output registers; reset holds the processor in reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      cnt_q       <= '0;
      prog_q      <= '0;
      tmask_q     <= '0;
      dut_reset_q <= 1'b1;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      cnt_q       <= cnt_d;
      prog_q      <= prog_d;
      tmask_q     <= tmask_d;
      dut_reset_q <= dut_reset_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Results stay readable across sequences until overwritten or reset.
  run_result_file #(
    .NUM_PROGS(NUM_PROGS)
  ) u_results (
    .clk  (Clk),
    .rst_n(Reset),
    .clr  (1'b0),
    .we   (rec_we),
    .waddr(prog_q),
    .wdata(cnt_q),
    .raddr(ResAddr),
    .rdata(ResCount)
  );

  assign DutReset    = dut_reset_q;
  assign Start       = start_q;
  assign ProgSel     = prog_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign TimeoutMask = tmask_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Testbench for run_sequencer: scripted processor plus per-cycle expected-output timeline.
// Latency: n/a.
// Backpressure: n/a.
module tb_run_sequencer;

  localparam int NP = 3;
  localparam int RC = 2;
  localparam int AB = 1;
  localparam int TO = 20;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Go;
  logic          Ack;
  logic          DutReset;
  logic          Start;
  logic [2:0]    ProgSel;
  logic          Busy;
  logic          Done;
  logic [2:0]    ResAddr;
  logic [15:0]   ResCount;
  logic [NP-1:0] TimeoutMask;

  run_sequencer #(
    .NUM_PROGS (NP),
    .RST_CYCLES(RC),
    .ACK_BLANK (AB),
    .TIMEOUT   (TO)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Go         (Go),
    .Ack        (Ack),
    .DutReset   (DutReset),
    .Start      (Start),
    .ProgSel    (ProgSel),
    .Busy       (Busy),
    .Done       (Done),
    .ResAddr    (ResAddr),
    .ResCount   (ResCount),
    .TimeoutMask(TimeoutMask)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // One expected cycle. ph: 0 idle, 1 rst, 2 start, 3 blank, 4 run, 5 record, 6 finish.
  typedef struct {
    int ph;
    int prog;
    int mask;
    bit ack;
    int rec_idx;
    int rec_val;
  } exp_t;

  exp_t q[$];
  int   exp_res[8];
  int   last_prog = 0;
  int   last_mask = 0;
  int   dly[NP];
  bit   stale = 1'b0;
  bit   noise = 1'b0;
  bit   go_req = 1'b0;
  int   addr_force = -1;
  int   seq_start_cnt = 0;
  int   seq_done_cnt = 0;
  int   cur_ph = 0;
  int   cur_prog = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int ph, input int prog, input int mask, input bit ack);
    exp_t e;
    e.ph = ph; e.prog = prog; e.mask = mask; e.ack = ack;
    e.rec_idx = -1; e.rec_val = 0;
    return e;
  endfunction

  // Expand one Go into the cycle-by-cycle timeline the sequencer must follow.
  // Program p sees dly[p] Ack-low RUN cycles before Ack, unless the count hits TO first.
  task automatic push_seq();
    int   mask;
    int   n0;
    bit   to;
    exp_t e;
    mask = 0;
    for (int p = 0; p < NP; p++) begin
      to = (dly[p] >= TO - AB);
      n0 = to ? (TO - AB) : dly[p];
      for (int i = 0; i < RC; i++) q.push_back(mk(1, p, mask, stale));
      q.push_back(mk(2, p, mask, stale));
      for (int i = 0; i < AB; i++) q.push_back(mk(3, p, mask, stale));
      for (int i = 0; i < n0; i++) q.push_back(mk(4, p, mask, 1'b0));
      if (!to) q.push_back(mk(4, p, mask, 1'b1));
      if (to) mask = mask | (1 << p);
      e = mk(5, p, mask, !to);
      e.rec_idx = p;
      e.rec_val = AB + n0;
      q.push_back(e);
    end
    q.push_back(mk(6, NP - 1, mask, 1'b0));
  endtask

  // Compare process: checks every cycle at negedge and drives the next stimulus.
  initial begin
    exp_t e;
    bit   idle;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        q.delete();
        last_prog = 0; last_mask = 0; cur_ph = 0; cur_prog = 0;
        foreach (exp_res[i]) exp_res[i] = 0;
        chk("rst_dutreset", DutReset, 1);
        chk("rst_start", Start, 0);
        chk("rst_progsel", ProgSel, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_tmask", TimeoutMask, 0);
        chk("rst_rescount", ResCount, 0);
        Go = 1'b0;
        Ack = 1'b0;
      end else begin
        idle = (q.size() == 0);
        if (idle) e = mk(0, last_prog, last_mask, 1'b0);
        else e = q.pop_front();
        chk("dutreset", DutReset, (e.ph == 1) ? 1 : 0);
        chk("start", Start, (e.ph == 2) ? 1 : 0);
        chk("busy", Busy, (e.ph != 0) ? 1 : 0);
        chk("done", Done, (e.ph == 6) ? 1 : 0);
        chk("progsel", ProgSel, e.prog);
        chk("tmask", TimeoutMask, e.mask);
        chk("rescount", ResCount, exp_res[ResAddr]);
        if (e.rec_idx >= 0) exp_res[e.rec_idx] = e.rec_val;
        last_prog = e.prog; last_mask = e.mask;
        cur_ph = e.ph; cur_prog = e.prog;
        if (e.ph == 6) seq_done_cnt++;
        Ack = e.ack;
        if (idle) begin
          Go = go_req;
          if (go_req) begin
            push_seq();
            seq_start_cnt++;
          end
        end else begin
          Go = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
      ResAddr = (addr_force >= 0) ? 3'(addr_force) : 3'($urandom_range(0, 7));
    end
  end

  task automatic wait_evt(input bit done_evt, input int budget, input string nm);
    int prev;
    bit got;
    prev = done_evt ? seq_done_cnt : seq_start_cnt;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge Clk); #1;
      if ((done_evt ? seq_done_cnt : seq_start_cnt) != prev) got = 1'b1;
    end
    chk(nm, got, 1);
  endtask

  // Directed sequence with hand-computed counts and mask checked after Done.
  task automatic run_dir(input int d0, input int d1, input int d2, input bit st, input bit nz,
                         input int c0, input int c1, input int c2, input int m);
    int c[NP];
    c[0] = c0; c[1] = c1; c[2] = c2;
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
    stale = st; noise = nz;
    go_req = 1'b1;
    wait_evt(1'b0, 20, "seq_start");
    go_req = 1'b0;
    @(posedge Clk); #1;
    chk("lat_rst_first", DutReset, 1);
    chk("lat_nostart", Start, 0);
    @(posedge Clk); #1;
    chk("lat_rst_second", DutReset, 1);
    @(posedge Clk); #1;
    chk("lat_start", Start, 1);
    chk("lat_rst_released", DutReset, 0);
    wait_evt(1'b1, 500, "seq_done");
    noise = 1'b0;
    for (int i = 0; i < NP; i++) begin
      addr_force = i;
      @(negedge Clk); #1;
      chk("count_lit", ResCount, c[i]);
    end
    addr_force = -1;
    chk("mask_lit", TimeoutMask, m);
  endtask

  initial begin
    bit found;
    Reset = 1'b0; Go = 1'b0; Ack = 1'b0; ResAddr = 3'd0;
    repeat (3) @(posedge Clk);
    #6 Reset = 1'b1;
    repeat (2) @(negedge Clk);
    #1;

    // Ack after 10 RUN cycles: 1 blank + 10 run.
    run_dir(10, 0, 0, 1'b0, 1'b0, 11, 1, 1, 0);
    // Ack held high throughout: blank masks it, every count is 1.
    run_dir(0, 0, 0, 1'b1, 1'b0, 1, 1, 1, 0);
    // Delays 5/0/7 with Go noise while busy.
    run_dir(5, 0, 7, 1'b0, 1'b1, 6, 1, 8, 0);
    // Timeouts on programs 0 and 2; program 1 acks on the would-be timeout cycle.
    run_dir(25, 18, 19, 1'b0, 1'b0, 20, 19, 20, 5);

    // Go held high across Done restarts after exactly one idle cycle.
    dly[0] = 3; dly[1] = 4; dly[2] = 2; stale = 1'b0;
    go_req = 1'b1;
    wait_evt(1'b0, 20, "b2b_first_start");
    wait_evt(1'b1, 500, "b2b_first_done");
    wait_evt(1'b0, 1, "b2b_restart_next_cycle");
    go_req = 1'b0;
    wait_evt(1'b1, 500, "b2b_second_done");

    // Reset during RUN of program 1 aborts and clears results.
    dly[0] = 2; dly[1] = 30; dly[2] = 2;
    go_req = 1'b1;
    wait_evt(1'b0, 20, "abort_start");
    go_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge Clk); #1;
      if (cur_ph == 4 && cur_prog == 1) found = 1'b1;
    end
    chk("abort_reached_run1", found, 1);
    @(posedge Clk); #2 Reset = 1'b0;
    #1;
    chk("abort_dutreset_async", DutReset, 1);
    chk("abort_busy_async", Busy, 0);
    repeat (3) @(posedge Clk);
    #6 Reset = 1'b1;
    repeat (6) @(negedge Clk);
    #1;
    chk("abort_no_restart", Busy, 0);
    addr_force = 0;
    @(negedge Clk); #1;
    chk("abort_res0_cleared", ResCount, 0);
    addr_force = -1;
    run_dir(1, 1, 1, 1'b0, 1'b0, 2, 2, 2, 0);

    // Randomized sequences checked cycle by cycle against the timeline.
    for (int k = 0; k < 8; k++) begin
      for (int p = 0; p < NP; p++) dly[p] = $urandom_range(0, 24);
      stale = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      go_req = 1'b1;
      wait_evt(1'b0, 20, "rand_start");
      go_req = 1'b0;
      wait_evt(1'b1, 500, "rand_done");
      noise = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      #1;
    end

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
